// File: rtl/pipelined_datapath.sv
// Two-stage execute datapath (EX + WB) with register file, ALU, shifter, flags
// and a req/ack load/store port that stalls issue while a memory op is pending.
module pipelined_datapath #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4,
  parameter int SHBITS  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic               use_imm,
  input  logic [WIDTH-1:0]   imm,
  input  logic [REGBITS-1:0] ra_src,
  input  logic [REGBITS-1:0] ra_dst,
  input  logic [SHBITS-1:0]  shamt,
  input  logic [1:0]         shift_op,
  input  logic               flag_we,
  output logic               mem_req,
  output logic               mem_we,
  output logic [WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]   mem_wdata,
  input  logic               mem_ack,
  input  logic [WIDTH-1:0]   mem_rdata,
  output logic [4:0]         flags,
  output logic               wb_valid,
  output logic [REGBITS-1:0] wb_addr,
  output logic [WIDTH-1:0]   wb_data
);

  localparam int NREGS = 1 << REGBITS;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_SHIFT = 3'd5, OP_LOAD = 3'd6, OP_STORE = 3'd7;

  typedef enum logic {IDLE, MEM} state_t;

  state_t               state, state_next;
  logic [WIDTH-1:0]     rf [NREGS];
  logic [REGBITS-1:0]   mem_dst;
  logic                 accept, is_mem, is_alu;
  logic [WIDTH-1:0]     a_op, src_val, b_op, sh_in, sh_res, alu_res;
  logic [WIDTH:0]       sum, diff;
  logic [4:0]           alu_flags;

  assign accept = in_valid & in_ready;
  assign is_mem = (op == OP_LOAD) || (op == OP_STORE);
  assign is_alu = (op <= OP_XOR);

  // Forward the WB result so a dependent instruction can issue the next cycle.
  assign a_op    = (wb_valid && wb_addr == ra_dst) ? wb_data : rf[ra_dst];
  assign src_val = (wb_valid && wb_addr == ra_src) ? wb_data : rf[ra_src];
  assign b_op    = use_imm ? imm : src_val;
  assign sh_in   = use_imm ? imm : a_op;

  always_comb begin
    sh_res = sh_in;
    case (shift_op)
      2'b00:   sh_res = sh_in << shamt;
      2'b01:   sh_res = sh_in >> shamt;
      2'b10:   sh_res = $unsigned($signed(sh_in) >>> shamt);
      default: sh_res = (sh_in >> shamt) | (sh_in << (WIDTH - int'(shamt)));
    endcase
  end

  assign sum  = {1'b0, a_op} + {1'b0, b_op};
  assign diff = {1'b0, a_op} - {1'b0, b_op};

  // Flags are {N,Z,F,L,C}; logic ops only touch N and Z.
  always_comb begin
    alu_res   = '0;
    alu_flags = flags;
    case (op)
      OP_ADD: begin
        alu_res      = sum[WIDTH-1:0];
        alu_flags[0] = sum[WIDTH];
        alu_flags[2] = (a_op[WIDTH-1] == b_op[WIDTH-1]) && (alu_res[WIDTH-1] != a_op[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res      = diff[WIDTH-1:0];
        alu_flags[0] = diff[WIDTH];
        alu_flags[1] = diff[WIDTH];
        alu_flags[2] = (a_op[WIDTH-1] != b_op[WIDTH-1]) && (alu_res[WIDTH-1] != a_op[WIDTH-1]);
      end
      OP_AND:   alu_res = a_op & b_op;
      OP_OR:    alu_res = a_op | b_op;
      OP_XOR:   alu_res = a_op ^ b_op;
      OP_SHIFT: alu_res = sh_res;
      default:  alu_res = '0;
    endcase
    alu_flags[3] = (alu_res == '0);
    alu_flags[4] = alu_res[WIDTH-1];
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    mem_req    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !reset;
        if (in_valid && !reset && is_mem) state_next = MEM;
      end
      MEM: begin
        mem_req = 1'b1;
        if (mem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      flags     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_dst   <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      state    <= state_next;
      wb_valid <= 1'b0;
      if (wb_valid) rf[wb_addr] <= wb_data;
      if (accept) begin
        if (is_mem) begin
          mem_we    <= (op == OP_STORE);
          mem_addr  <= b_op;
          mem_wdata <= a_op;
          mem_dst   <= ra_dst;
        end else begin
          wb_valid <= 1'b1;
          wb_addr  <= ra_dst;
          wb_data  <= alu_res;
        end
        if (flag_we && is_alu) flags <= alu_flags;
      end else if (state == MEM && mem_ack && !mem_we) begin
        wb_valid <= 1'b1;
        wb_addr  <= mem_dst;
        wb_data  <= mem_rdata;
      end
    end
  end

endmodule
